// File: rtl/game_pkg.sv
// Shared game-core definitions: default geometry/speeds, mapper FSM encoding,
// and the rounded fixed-point scale constants for the velocity mapper.
package game_pkg;

  localparam int MIN_VEL_DEF    = 400;
  localparam int MAX_VEL_DEF    = 600;
  localparam int PDL_HEIGHT_DEF = 96;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SAT  = 2'd2
  } vrm_state_e;

  // x gain per px of hit offset, rounded to nearest in FRAC fractional bits
  function automatic int dx_const(input int min_vel, input int max_vel,
                                  input int pdl_h, input int frac);
    return (2 * (max_vel - min_vel) * (1 << frac) + pdl_h / 2) / pdl_h;
  endfunction

  function automatic int dy_const(input int max_vel, input int pdl_h, input int frac);
    return (2 * max_vel * (1 << frac) + pdl_h / 2) / pdl_h;
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Sequential LSB-first shift-add multiplier: B_W cycles after start, done
// pulses for one cycle with the full product on prod.
module shift_add_mul #(
  parameter int A_W = 11,
  parameter int B_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               done,
  output logic [A_W+B_W-1:0] prod
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(B_W + 1);

  logic [P_W-1:0]   mcand_q, mcand_d;
  logic [B_W-1:0]   mplier_q, mplier_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    // a new start overrides anything still in flight
    if (start) begin
      mcand_d  = P_W'(a);
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CNT_W'(B_W);
    end else if (cnt_q != '0) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      done_d   = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;
  assign prod = acc_q;

endmodule

// File: rtl/velocity_ramp_mapper.sv
// Maps a paddle hit offset to new square x/y speeds and directions, with a
// rally speed ramp; products come from two shift-add multipliers run together.
module velocity_ramp_mapper
  import game_pkg::*;
#(
  parameter int MIN_VEL    = MIN_VEL_DEF,
  parameter int MAX_VEL    = MAX_VEL_DEF,
  parameter int PDL_HEIGHT = PDL_HEIGHT_DEF,
  parameter int HIT_W      = 7,
  parameter int FRAC       = 8,
  parameter int RAMP_STEP  = 20,
  parameter int RAMP_MAX   = 8,
  parameter int VEL_WIDTH  = $clog2(MAX_VEL + RAMP_STEP * RAMP_MAX + 1),
  parameter int RC_W       = $clog2(RAMP_MAX + 1)
) (
  input  logic                 clk_0,
  input  logic                 rst,
  input  logic                 paddle_hit,
  input  logic                 hit_side,
  input  logic                 hit_up,
  input  logic [HIT_W-1:0]     hit_y,
  input  logic                 sq_missed,
  input  logic                 game_over,
  input  logic                 game_startup,
  output logic [VEL_WIDTH-1:0] sq_xvel,
  output logic [VEL_WIDTH-1:0] sq_yvel,
  output logic                 sq_xdir,
  output logic                 sq_ydir,
  output logic [RC_W-1:0]      rally_cnt,
  output logic                 busy,
  output logic                 vel_valid,
  output logic                 hit_drop
);

  localparam int DX   = dx_const(MIN_VEL, MAX_VEL, PDL_HEIGHT, FRAC);
  localparam int DY   = dy_const(MAX_VEL, PDL_HEIGHT, FRAC);
  localparam int DX_W = $clog2(DX + 1);
  localparam int DY_W = $clog2(DY + 1);
  localparam int PX_W = DX_W + HIT_W;
  localparam int PY_W = DY_W + HIT_W;

  localparam logic [DX_W-1:0]      DX_V     = DX_W'(DX);
  localparam logic [DY_W-1:0]      DY_V     = DY_W'(DY);
  localparam logic [HIT_W-1:0]     HALF_H   = HIT_W'(PDL_HEIGHT / 2);
  localparam logic [RC_W-1:0]      RC_MAX   = RC_W'(RAMP_MAX);
  localparam logic [VEL_WIDTH-1:0] VEL_BASE = VEL_WIDTH'(MIN_VEL);
  localparam logic [31:0]          VMAX     = 32'((1 << VEL_WIDTH) - 1);

  vrm_state_e           state_q, state_d;
  logic [VEL_WIDTH-1:0] xvel_q, xvel_d, yvel_q, yvel_d;
  logic                 xdir_q, xdir_d, ydir_q, ydir_d;
  logic [RC_W-1:0]      rally_q, rally_d, r_q, r_d;
  logic                 side_q, side_d, up_q, up_d;
  logic                 busy_q, busy_d, vv_q, vv_d, drop_q, drop_d;

  logic                 base_evt, mul_start, mul_done, mul_done_y;
  logic [HIT_W-1:0]     hy_c;
  logic [PX_W-1:0]      px;
  logic [PY_W-1:0]      py;
  logic [31:0]          x_sum, y_sum;

  assign base_evt = sq_missed | game_over | game_startup;
  assign hy_c     = (hit_y > HALF_H) ? HALF_H : hit_y;
  assign x_sum    = 32'(MIN_VEL) + 32'(RAMP_STEP) * 32'(r_q) + 32'(px >> FRAC);
  assign y_sum    = 32'(py >> FRAC);

  shift_add_mul #(.A_W(DX_W), .B_W(HIT_W)) u_mul_x (
    .clk(clk_0), .rst(rst), .start(mul_start), .a(DX_V), .b(hy_c),
    .done(mul_done), .prod(px)
  );

  shift_add_mul #(.A_W(DY_W), .B_W(HIT_W)) u_mul_y (
    .clk(clk_0), .rst(rst), .start(mul_start), .a(DY_V), .b(hy_c),
    .done(mul_done_y), .prod(py)
  );

  always_comb begin
    state_d   = state_q;
    xvel_d    = xvel_q;
    yvel_d    = yvel_q;
    xdir_d    = xdir_q;
    ydir_d    = ydir_q;
    rally_d   = rally_q;
    r_d       = r_q;
    side_d    = side_q;
    up_d      = up_q;
    busy_d    = busy_q;
    vv_d      = 1'b0;
    drop_d    = 1'b0;
    mul_start = 1'b0;
    // a base event silently swallows a coincident hit and any in-flight result
    if (base_evt) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      xvel_d  = VEL_BASE;
      yvel_d  = VEL_BASE;
      rally_d = '0;
    end else begin
      if (paddle_hit && state_q != ST_IDLE) drop_d = 1'b1;
      unique case (state_q)
        ST_IDLE: if (paddle_hit) begin
          mul_start = 1'b1;
          r_d       = rally_q;
          side_d    = hit_side;
          up_d      = hit_up;
          busy_d    = 1'b1;
          state_d   = ST_MUL;
        end
        ST_MUL: if (mul_done) state_d = ST_SAT;
        ST_SAT: begin
          xvel_d  = (x_sum > VMAX) ? VMAX[VEL_WIDTH-1:0] : x_sum[VEL_WIDTH-1:0];
          yvel_d  = (y_sum > VMAX) ? VMAX[VEL_WIDTH-1:0] : y_sum[VEL_WIDTH-1:0];
          xdir_d  = ~side_q;
          ydir_d  = ~up_q;
          rally_d = (r_q >= RC_MAX) ? RC_MAX : r_q + RC_W'(1);
          vv_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_0) begin
    if (rst) begin
      state_q <= ST_IDLE;
      xvel_q  <= VEL_BASE;
      yvel_q  <= VEL_BASE;
      xdir_q  <= 1'b1;
      ydir_q  <= 1'b1;
      rally_q <= '0;
      r_q     <= '0;
      side_q  <= 1'b0;
      up_q    <= 1'b0;
      busy_q  <= 1'b0;
      vv_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xvel_q  <= xvel_d;
      yvel_q  <= yvel_d;
      xdir_q  <= xdir_d;
      ydir_q  <= ydir_d;
      rally_q <= rally_d;
      r_q     <= r_d;
      side_q  <= side_d;
      up_q    <= up_d;
      busy_q  <= busy_d;
      vv_q    <= vv_d;
      drop_q  <= drop_d;
    end
  end

  assign sq_xvel   = xvel_q;
  assign sq_yvel   = yvel_q;
  assign sq_xdir   = xdir_q;
  assign sq_ydir   = ydir_q;
  assign rally_cnt = rally_q;
  assign busy      = busy_q;
  assign vel_valid = vv_q;
  assign hit_drop  = drop_q;

endmodule

// File: tb/tb_velocity_ramp_mapper.sv
// Directed + randomized bench for velocity_ramp_mapper against an arithmetic
// reference of the hit-to-velocity rules.
module tb_velocity_ramp_mapper;

  localparam int VW = 10;
  localparam int RW = 4;

  logic          clk_0 = 1'b0;
  logic          rst = 1'b1;
  logic          paddle_hit = 1'b0, hit_side = 1'b0, hit_up = 1'b0;
  logic [6:0]    hit_y = '0;
  logic          sq_missed = 1'b0, game_over = 1'b0, game_startup = 1'b0;
  logic [VW-1:0] sq_xvel, sq_yvel;
  logic          sq_xdir, sq_ydir, busy, vel_valid, hit_drop;
  logic [RW-1:0] rally_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // reference state
  int m_x = 400, m_y = 400, m_xd = 1, m_yd = 1, m_r = 0;

  velocity_ramp_mapper dut (
    .clk_0(clk_0), .rst(rst), .paddle_hit(paddle_hit), .hit_side(hit_side),
    .hit_up(hit_up), .hit_y(hit_y), .sq_missed(sq_missed), .game_over(game_over),
    .game_startup(game_startup), .sq_xvel(sq_xvel), .sq_yvel(sq_yvel),
    .sq_xdir(sq_xdir), .sq_ydir(sq_ydir), .rally_cnt(rally_cnt), .busy(busy),
    .vel_valid(vel_valid), .hit_drop(hit_drop)
  );

  always #20 clk_0 = ~clk_0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_xvel"}, 32'(sq_xvel), m_x);
    chk({tag, "_yvel"}, 32'(sq_yvel), m_y);
    chk({tag, "_xdir"}, 32'(sq_xdir), m_xd);
    chk({tag, "_ydir"}, 32'(sq_ydir), m_yd);
    chk({tag, "_rally"}, 32'(rally_cnt), m_r);
  endtask

  task automatic model_base();
    m_x = 400; m_y = 400; m_r = 0;
  endtask

  // Spec arithmetic: DX=1067, DY=3200, FRAC=8, clip to 48, saturate to 1023
  task automatic model_hit(input int y, input int side, input int up);
    int hy, x, yv;
    hy = (y > 48) ? 48 : y;
    x  = 400 + 20 * m_r + (1067 * hy) / 256;
    yv = (3200 * hy) / 256;
    m_x  = (x > 1023) ? 1023 : x;
    m_y  = (yv > 1023) ? 1023 : yv;
    m_xd = side ? 0 : 1;
    m_yd = up ? 0 : 1;
    m_r  = (m_r + 1 > 8) ? 8 : m_r + 1;
  endtask

  // kind 0: clean hit; 1: extra hit at cycle ev (dropped); 2: sq_missed at cycle ev
  task automatic run_hit(input int y, input int side, input int up,
                         input int kind, input int ev);
    int vv_at9, vv_other;
    vv_at9 = 0; vv_other = 0;
    @(negedge clk_0);
    paddle_hit = 1'b1; hit_y = 7'(y); hit_side = side[0]; hit_up = up[0];
    @(posedge clk_0); #1;
    chk("busy_after_E0", 32'(busy), 1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_0);
      paddle_hit = 1'b0; sq_missed = 1'b0;
      if (k == ev && kind == 1) begin
        paddle_hit = 1'b1; hit_y = 7'($urandom_range(0, 127));
        hit_side = ~hit_side; hit_up = ~hit_up;
      end
      if (k == ev && kind == 2) sq_missed = 1'b1;
      @(posedge clk_0); #1;
      if (vel_valid === 1'b1) begin
        if (k == 9) vv_at9++; else vv_other++;
      end
      if (kind == 1 && k == ev)     chk("hit_drop_pulse", 32'(hit_drop), 1);
      if (kind == 1 && k == ev + 1) chk("hit_drop_clear", 32'(hit_drop), 0);
      if (kind == 2 && k == ev) begin
        model_base();
        chk("miss_busy", 32'(busy), 0);
        chk_state("miss_mid");
      end
    end
    @(negedge clk_0);
    paddle_hit = 1'b0; sq_missed = 1'b0;
    chk("vv_early", vv_other, 0);
    if (kind == 2) begin
      chk("vv_after_miss", vv_at9, 0);
      chk_state("after_miss");
    end else begin
      model_hit(y, side, up);
      chk("vv_at_9", vv_at9, 1);
      chk("busy_done", 32'(busy), 0);
      chk_state("result");
    end
  endtask

  task automatic pulse_miss();
    @(negedge clk_0);
    sq_missed = 1'b1;
    @(posedge clk_0); #1;
    model_base();
    chk_state("miss");
    @(negedge clk_0);
    sq_missed = 1'b0;
  endtask

  initial begin
    int vv_seen;
    repeat (3) @(posedge clk_0);
    @(negedge clk_0);
    rst = 1'b0;
    @(posedge clk_0); #1;
    chk_state("reset");
    chk("reset_busy", 32'(busy), 0);
    chk("reset_vv", 32'(vel_valid), 0);
    chk("reset_drop", 32'(hit_drop), 0);

    // edge hit: expect (600, 600), xdir 1, ydir 0, rally 1
    run_hit(48, 0, 1, 0, 0);
    chk("edge_x_const", 32'(sq_xvel), 600);
    chk("edge_y_const", 32'(sq_yvel), 600);

    // ramp sequence from rally 0: (500,300), (420,0), (640,600)
    pulse_miss();
    run_hit(24, 1, 0, 0, 0);
    run_hit(0, 0, 0, 0, 0);
    run_hit(100, 1, 1, 0, 0);
    chk("clip_ramp_x", 32'(sq_xvel), 640);

    // rally and x speed saturation with centre hits
    pulse_miss();
    for (int i = 0; i < 10; i++) begin
      run_hit(0, i & 1, 0, 0, 0);
      repeat (2) @(negedge clk_0);
    end
    chk("sat_rally", 32'(rally_cnt), 8);
    chk("sat_xvel", 32'(sq_xvel), 560);

    // busy hit dropped; miss mid-computation
    run_hit(30, 0, 1, 1, 3);
    run_hit(30, 1, 0, 2, 4);

    // miss together with a hit: hit swallowed, no drop, no result
    run_hit(10, 1, 1, 0, 0);
    @(negedge clk_0);
    paddle_hit = 1'b1; sq_missed = 1'b1; hit_y = 7'd40; hit_side = 1'b0; hit_up = 1'b0;
    @(posedge clk_0); #1;
    model_base();
    chk("coinc_busy", 32'(busy), 0);
    @(negedge clk_0);
    paddle_hit = 1'b0; sq_missed = 1'b0;
    vv_seen = 0;
    for (int k = 0; k < 11; k++) begin
      @(posedge clk_0); #1;
      if (vel_valid === 1'b1 || hit_drop === 1'b1) vv_seen++;
    end
    chk("coinc_no_pulse", vv_seen, 0);
    chk_state("coinc");

    // randomized hits with occasional drop/miss interference
    for (int i = 0; i < 30; i++) begin
      int kind;
      kind = $urandom_range(0, 5);
      kind = (kind < 4) ? 0 : kind - 3;
      run_hit($urandom_range(0, 127), $urandom_range(0, 1), $urandom_range(0, 1),
              kind, $urandom_range(1, 8));
      repeat ($urandom_range(0, 2)) @(negedge clk_0);
    end

    // synchronous reset restores directions too
    @(negedge clk_0);
    rst = 1'b1;
    @(posedge clk_0); #1;
    model_base(); m_xd = 1; m_yd = 1;
    chk_state("rst_again");
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
